button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 180 ++++++++++++++++++
 tb/tb_button_conditioner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Button conditioner: five raw buttons are synchronized, debounced on the
// millisecond tick, and turned into one-cycle press pulses plus stable levels.
// Optional macro BUTTON_CONDITIONER_AUTOREPEAT_EN adds hold-to-repeat on the
// up and down buttons; without it every button gives one pulse per press.
`timescale 1ns/1ps

module button_conditioner #(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ms_pulse,
  input  logic [4:0] i_btn,
  output logic       o_mode,
  output logic       o_up,
  output logic       o_down,
  output logic       o_left,
  output logic       o_right,
  output logic [4:0] o_held
);

  localparam int DB_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);

  logic [4:0]      sync_meta;
  logic [4:0]      sync_btn;
  logic [4:0]      stable;
  logic [4:0]      stable_prev;
  logic [4:0]      rise;
  logic [4:0]      pulse_next;
  logic [4:0]      pulse;
  logic [DB_W-1:0] db_cnt [5];

  // Two-flop synchronizer so the raw buttons never reach logic directly
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_meta <= '0;
      sync_btn  <= '0;
    end else begin
      sync_meta <= i_btn;
      sync_btn  <= sync_meta;
    end
  end

  // A level is only accepted after it has disagreed with the stable value for DEBOUNCE_MS ticks in a row
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stable <= '0;
      for (int i = 0; i < 5; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync_btn[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (i_ms_pulse) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= ~stable[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end
      end
    end
  end

  // Previous stable level, used to spot the 0->1 edge of an accepted press
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stable_prev <= '0;
    end else begin
      stable_prev <= stable;
    end
  end

  assign rise   = stable & ~stable_prev;
  assign o_held = stable;

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY_MS - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE_MS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  // Index 0 serves down (bit 2), index 1 serves up (bit 3)
  rpt_state_t       rpt_state      [2];
  rpt_state_t       rpt_state_next [2];
  logic [RPT_W-1:0] rpt_cnt        [2];
  logic [RPT_W-1:0] rpt_cnt_next   [2];
  logic [1:0]       fire;

  // Repeat FSM state and ms counters for up and down
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int j = 0; j < 2; j++) begin
        rpt_state[j] <= IDLE;
        rpt_cnt[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        rpt_state[j] <= rpt_state_next[j];
        rpt_cnt[j]   <= rpt_cnt_next[j];
      end
    end
  end

  // Press arms the delay, the delay expiry starts repeating, a release always drops back to idle silently
  always_comb begin
    rpt_state_next = rpt_state;
    rpt_cnt_next   = rpt_cnt;
    fire           = '0;
    for (int j = 0; j < 2; j++) begin
      case (rpt_state[j])
        IDLE: begin
          if (rise[2+j]) begin
            rpt_state_next[j] = DELAY;
            rpt_cnt_next[j]   = '0;
          end
        end
        DELAY: begin
          if (!stable[2+j]) begin
            rpt_state_next[j] = IDLE;
            rpt_cnt_next[j]   = '0;
          end else if (i_ms_pulse) begin
            if (rpt_cnt[j] == DELAY_LAST) begin
              fire[j]           = 1'b1;
              rpt_state_next[j] = REPEAT;
              rpt_cnt_next[j]   = '0;
            end else if (rpt_cnt[j] != '1) begin
              rpt_cnt_next[j] = rpt_cnt[j] + RPT_W'(1);
            end
          end
        end
        REPEAT: begin
          if (!stable[2+j]) begin
            rpt_state_next[j] = IDLE;
            rpt_cnt_next[j]   = '0;
          end else if (i_ms_pulse) begin
            if (rpt_cnt[j] == RATE_LAST) begin
              fire[j]         = 1'b1;
              rpt_cnt_next[j] = '0;
            end else if (rpt_cnt[j] != '1) begin
              rpt_cnt_next[j] = rpt_cnt[j] + RPT_W'(1);
            end
          end
        end
        default: begin
          rpt_state_next[j] = IDLE;
          rpt_cnt_next[j]   = '0;
        end
      endcase
    end
  end

  assign pulse_next = rise | {1'b0, fire[1], fire[0], 2'b00};
`else
  assign pulse_next = rise;
`endif

  // Registered press pulses, one cycle wide
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pulse <= '0;
    end else begin
      pulse <= pulse_next;
    end
  end

  assign {o_mode, o_up, o_down, o_left, o_right} = pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios plus random button
// activity, every cycle compared against a tick-counting reference model.
// Honors BUTTON_CONDITIONER_AUTOREPEAT_EN the same way the design does.
`timescale 1ns/1ps

module tb_button_conditioner;

  localparam int DEB   = 3;
  localparam int DLY   = 5;
  localparam int RATE  = 2;
  localparam int MS_PERIOD = 10;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_ms_pulse = 1'b0;
  logic [4:0] i_btn = '0;
  logic       o_mode, o_up, o_down, o_left, o_right;
  logic [4:0] o_held;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state
  logic [4:0] m_in_d1, m_in_d2;
  logic [4:0] m_stable;
  logic [4:0] m_rise_pend;
  logic [4:0] exp_pulse;
  int         m_deb_ticks [5];
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  bit         m_armed     [5];
  int         m_rep_ticks [5];
`endif

  int obs_up_cnt = 0, exp_up_cnt = 0;
  int obs_right_cnt = 0, exp_right_cnt = 0;
  int obs_mode_cnt = 0, exp_mode_cnt = 0;
  int obs_down_cnt = 0, exp_down_cnt = 0;

  button_conditioner #(
    .DEBOUNCE_MS    (DEB),
    .REPEAT_DELAY_MS(DLY),
    .REPEAT_RATE_MS (RATE)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_ms_pulse(i_ms_pulse),
    .i_btn     (i_btn),
    .o_mode    (o_mode),
    .o_up      (o_up),
    .o_down    (o_down),
    .o_left    (o_left),
    .o_right   (o_right),
    .o_held    (o_held)
  );

  // Free-running clock
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      if (errors <= 30) begin
        $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
      end
    end
  endtask

  task automatic modelReset();
    m_in_d1     = '0;
    m_in_d2     = '0;
    m_stable    = '0;
    m_rise_pend = '0;
    exp_pulse   = '0;
    for (int b = 0; b < 5; b++) begin
      m_deb_ticks[b] = 0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      m_armed[b]     = 1'b0;
      m_rep_ticks[b] = 0;
`endif
    end
  endtask

  // One clock edge of the model, using the values present just before the edge
  task automatic modelStep();
    logic [4:0] new_pulse;
    logic [4:0] new_rise;
    new_pulse = m_rise_pend;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    // Repeats fall at DLY ticks after the press, then every RATE ticks, while still held
    for (int k = 2; k <= 3; k++) begin
      if (m_armed[k]) begin
        if (!m_stable[k]) begin
          m_armed[k] = 1'b0;
        end else if (i_ms_pulse) begin
          m_rep_ticks[k]++;
          if (m_rep_ticks[k] == DLY ||
              (m_rep_ticks[k] > DLY && ((m_rep_ticks[k] - DLY) % RATE) == 0)) begin
            new_pulse[k] = 1'b1;
          end
        end
      end
      if (m_rise_pend[k]) begin
        m_armed[k]     = 1'b1;
        m_rep_ticks[k] = 0;
      end
    end
`endif
    new_rise = '0;
    for (int b = 0; b < 5; b++) begin
      if (m_in_d2[b] == m_stable[b]) begin
        m_deb_ticks[b] = 0;
      end else if (i_ms_pulse) begin
        m_deb_ticks[b]++;
        if (m_deb_ticks[b] == DEB) begin
          m_stable[b]    = ~m_stable[b];
          m_deb_ticks[b] = 0;
          new_rise[b]    = m_stable[b];
        end
      end
    end
    m_rise_pend = new_rise;
    exp_pulse   = new_pulse;
    m_in_d2     = m_in_d1;
    m_in_d1     = i_btn;
  endtask

  // Drive one cycle of inputs, advance the model, compare all outputs
  task automatic applyStimulus(input logic [4:0] b, input logic r);
    @(negedge i_clk);
    i_btn      = b;
    i_rst      = r;
    i_ms_pulse = ((cyc % MS_PERIOD) == MS_PERIOD - 1);
    cyc++;
    if (r) modelReset();
    @(posedge i_clk);
    if (!r) modelStep();
    #1;
    checkOutput("outputs", {22'd0, o_mode, o_up, o_down, o_left, o_right, o_held},
                {22'd0, exp_pulse, m_stable});
    obs_up_cnt    += int'(o_up);
    exp_up_cnt    += int'(exp_pulse[3]);
    obs_right_cnt += int'(o_right);
    exp_right_cnt += int'(exp_pulse[0]);
    obs_mode_cnt  += int'(o_mode);
    exp_mode_cnt  += int'(exp_pulse[4]);
    obs_down_cnt  += int'(o_down);
    exp_down_cnt  += int'(exp_pulse[2]);
  endtask

  task automatic holdFor(input logic [4:0] b, input int n);
    for (int i = 0; i < n; i++) applyStimulus(b, 1'b0);
  endtask

  task automatic clearCounts();
    obs_up_cnt = 0; exp_up_cnt = 0;
    obs_right_cnt = 0; exp_right_cnt = 0;
    obs_mode_cnt = 0; exp_mode_cnt = 0;
    obs_down_cnt = 0; exp_down_cnt = 0;
  endtask

  // Main stimulus sequence
  initial begin
    logic [4:0] rnd_btn;
    int         rst_left;
    modelReset();
    $display("[TB] start");

    for (int i = 0; i < 3; i++) applyStimulus(5'b00000, 1'b1);
    checkOutput("reset_state", {26'd0, o_mode, o_up, o_down, o_left, o_right, o_held}, 32'd0);
    holdFor(5'b00000, 10);

    // Left held steadily, then released
    holdFor(5'b00010, 60);
    checkOutput("left_held", {31'd0, o_held[1]}, 32'd1);
    holdFor(5'b00000, 60);

    // Right bouncing every 15 clocks, never accepted
    clearCounts();
    for (int i = 0; i < 100; i++) applyStimulus(((i / 15) % 2 == 0) ? 5'b00001 : 5'b00000, 1'b0);
    holdFor(5'b00000, 60);
    checkOutput("right_bounce_pulses", obs_right_cnt, exp_right_cnt);
    checkOutput("right_bounce_none", obs_right_cnt, 0);

    // Up held for 200 clocks
    clearCounts();
    holdFor(5'b01000, 200);
    holdFor(5'b00000, 60);
    checkOutput("up_hold_pulses", obs_up_cnt, exp_up_cnt);

    // Mode and down pressed together
    clearCounts();
    holdFor(5'b10100, 60);
    holdFor(5'b00000, 60);
    checkOutput("mode_pulses", obs_mode_cnt, exp_mode_cnt);
    checkOutput("down_pulses", obs_down_cnt, exp_down_cnt);

    // Reset during up repeat with up still held
    clearCounts();
    holdFor(5'b01000, 120);
    for (int i = 0; i < 5; i++) applyStimulus(5'b01000, 1'b1);
    checkOutput("reset_mid_repeat", {26'd0, o_mode, o_up, o_down, o_left, o_right, o_held}, 32'd0);
    holdFor(5'b01000, 150);
    holdFor(5'b00000, 60);
    checkOutput("up_after_reset_pulses", obs_up_cnt, exp_up_cnt);

    // Random button activity with occasional resets
    clearCounts();
    rnd_btn  = '0;
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, 39) == 0) rnd_btn[b] = ~rnd_btn[b];
      end
      if (rst_left == 0 && $urandom_range(0, 599) == 0) rst_left = 4;
      applyStimulus(rnd_btn, rst_left != 0);
      if (rst_left != 0) rst_left--;
    end
    holdFor(5'b00000, 60);
    checkOutput("random_up_pulses", obs_up_cnt, exp_up_cnt);
    checkOutput("random_down_pulses", obs_down_cnt, exp_down_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
